// File: rtl/chrono_pkg.sv
// Shared types and BCD helpers for the chrono_engine timekeeping core.
// The time value and the lap entries share one packed {min, sec, ms_10} layout.
package chrono_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } chrono_state_e;

    localparam logic [7:0] BCD_59 = 8'h59;
    localparam logic [7:0] BCD_99 = 8'h99;
    localparam int         LAP_W  = 24;

    typedef struct packed {
        logic [7:0] min;
        logic [7:0] sec;
        logic [7:0] ms_10;
    } lap_t;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic logic bcd_ok(input logic [7:0] b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] b);
        if (b[3:0] == 4'd9) begin
            return {b[7:4] + 4'd1, 4'd0};
        end
        return {b[7:4], b[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] b);
        if (b[3:0] == 4'd0) begin
            return {b[7:4] - 4'd1, 4'd9};
        end
        return {b[7:4], b[3:0] - 4'd1};
    endfunction

endpackage

// File: rtl/bcd_time_step.sv
// Combinational one-step increment/decrement of a BCD {min, sec, ms_10} value.
// term_o flags the end of counting: saturation when counting up, zero when counting down.
module bcd_time_step
    import chrono_pkg::*;
#(
    parameter int MAX_MIN = 99
) (
    input  lap_t cur_i,
    input  logic down_i,
    output lap_t nxt_o,
    output logic term_o
);

    localparam logic [7:0] MAX_MIN_BCD = to_bcd(MAX_MIN);

    always_comb begin
        nxt_o  = cur_i;
        term_o = 1'b0;
        if (!down_i) begin
            // At the ceiling the value is held rather than wrapped.
            if (cur_i.min == MAX_MIN_BCD && cur_i.sec == BCD_59 && cur_i.ms_10 == BCD_99) begin
                term_o = 1'b1;
            end else if (cur_i.ms_10 != BCD_99) begin
                nxt_o.ms_10 = bcd_inc(cur_i.ms_10);
            end else begin
                nxt_o.ms_10 = 8'h00;
                if (cur_i.sec != BCD_59) begin
                    nxt_o.sec = bcd_inc(cur_i.sec);
                end else begin
                    nxt_o.sec = 8'h00;
                    nxt_o.min = bcd_inc(cur_i.min);
                end
            end
        end else begin
            if (cur_i == '0) begin
                term_o = 1'b1;
            end else begin
                if (cur_i.ms_10 != 8'h00) begin
                    nxt_o.ms_10 = bcd_dec(cur_i.ms_10);
                end else begin
                    nxt_o.ms_10 = BCD_99;
                    if (cur_i.sec != 8'h00) begin
                        nxt_o.sec = bcd_dec(cur_i.sec);
                    end else begin
                        nxt_o.sec = BCD_59;
                        nxt_o.min = bcd_dec(cur_i.min);
                    end
                end
                term_o = (nxt_o == '0);
            end
        end
    end

endmodule

// File: rtl/chrono_engine.sv
// Stopwatch / countdown engine: 10 ms prescaler, BCD time base, preset load
// and a lap-record FIFO whose head is presented on registered outputs.
module chrono_engine
    import chrono_pkg::*;
#(
    parameter int TICK_DIV  = 100000,
    parameter int LAP_DEPTH = 4,
    parameter int MAX_MIN   = 99
) (
    input  logic                         clk_core,
    input  logic                         rst_n,
    input  logic                         mode_i,
    input  logic                         start_stop_i,
    input  logic                         clear_i,
    input  logic                         load_i,
    input  logic [7:0]                   load_min_i,
    input  logic [7:0]                   load_sec_i,
    input  logic                         lap_i,
    input  logic                         lap_rd_i,
    output logic [7:0]                   min_o,
    output logic [7:0]                   sec_o,
    output logic [7:0]                   ms_10_o,
    output logic                         running_o,
    output logic                         time_out_o,
    output logic [7:0]                   lap_min_o,
    output logic [7:0]                   lap_sec_o,
    output logic [7:0]                   lap_ms_10_o,
    output logic                         lap_valid_o,
    output logic [$clog2(LAP_DEPTH):0]   lap_count_o,
    output logic                         lap_ovf_o
);

    localparam int             PW          = $clog2(TICK_DIV);
    localparam int             AW          = $clog2(LAP_DEPTH);
    localparam int             CW          = AW + 1;
    localparam logic [PW-1:0]  TICK_LAST   = PW'(TICK_DIV - 1);
    localparam logic [7:0]     MAX_MIN_BCD = to_bcd(MAX_MIN);

    chrono_state_e state_q;
    logic          mode_q;
    logic          running_q;
    logic          done_q;
    logic [PW-1:0] presc_q;
    lap_t          time_q;
    lap_t          step_time;
    logic          step_term;
    logic          tick;
    logic [7:0]    load_min_c;
    logic [7:0]    load_sec_c;

    assign tick       = (state_q == ST_RUN) && (presc_q == TICK_LAST);
    assign load_min_c = (bcd_ok(load_min_i) && load_min_i <= MAX_MIN_BCD) ? load_min_i : MAX_MIN_BCD;
    assign load_sec_c = (bcd_ok(load_sec_i) && load_sec_i <= BCD_59) ? load_sec_i : BCD_59;

    bcd_time_step #(.MAX_MIN(MAX_MIN)) u_step (
        .cur_i  (time_q),
        .down_i (mode_q),
        .nxt_o  (step_time),
        .term_o (step_term)
    );

    // Priority: clear, then load, then start_stop, then tick.
    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mode_q    <= 1'b0;
            presc_q   <= '0;
            time_q    <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else if (clear_i) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            time_q    <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load_i) begin
                        time_q <= {load_min_c, load_sec_c, 8'h00};
                    end else if (start_stop_i) begin
                        state_q   <= ST_RUN;
                        mode_q    <= mode_i;
                        presc_q   <= '0;
                        running_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (start_stop_i) begin
                        state_q   <= ST_PAUSE;
                        running_q <= 1'b0;
                    end else if (mode_q && time_q == '0) begin
                        state_q   <= ST_DONE;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else if (tick) begin
                        presc_q <= '0;
                        time_q  <= step_time;
                        if (step_term) begin
                            state_q   <= ST_DONE;
                            running_q <= 1'b0;
                            done_q    <= 1'b1;
                        end
                    end else begin
                        presc_q <= presc_q + PW'(1);
                    end
                end
                ST_PAUSE: begin
                    if (start_stop_i) begin
                        state_q   <= ST_RUN;
                        presc_q   <= '0;
                        running_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    rd_ptr_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             ovf_q;
    lap_t             head_q;
    lap_t             head_d;
    logic [LAP_W-1:0] mem_q [LAP_DEPTH];
    logic             lap_req;
    logic             full;
    logic             push_en;
    logic             pop_en;

    assign lap_req = !clear_i && lap_i && (state_q == ST_RUN || state_q == ST_PAUSE);
    assign full    = (count_q == CW'(LAP_DEPTH));
    assign pop_en  = !clear_i && lap_rd_i && (count_q != '0);
    assign push_en = lap_req && (!full || pop_en);

    // The head register looks ahead at the post-update FIFO, bypassing a push that lands on it.
    always_comb begin
        rd_ptr_d = pop_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push_en) - CW'(pop_en);
        head_d   = '0;
        if (count_d != '0) begin
            if (push_en && rd_ptr_d == wr_ptr_q) begin
                head_d = time_q;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk_core) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= time_q;
        end
    end

    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            head_q   <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            head_q   <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            if (lap_req && !push_en) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign min_o       = time_q.min;
    assign sec_o       = time_q.sec;
    assign ms_10_o     = time_q.ms_10;
    assign running_o   = running_q;
    assign time_out_o  = done_q;
    assign lap_min_o   = head_q.min;
    assign lap_sec_o   = head_q.sec;
    assign lap_ms_10_o = head_q.ms_10;
    assign lap_valid_o = (count_q != '0);
    assign lap_count_o = count_q;
    assign lap_ovf_o   = ovf_q;

endmodule

// File: tb/tb_chrono_engine.sv
// Directed plus randomized bench for chrono_engine, checked every cycle against a
// model that keeps time as plain centiseconds and the lap FIFO as a queue.
module tb_chrono_engine;

    localparam int TICK_DIV  = 4;
    localparam int LAP_DEPTH = 4;
    localparam int MAX_MIN   = 99;
    localparam int MAX_CS    = MAX_MIN * 6000 + 5999;

    logic       clk_core = 1'b0;
    logic       rst_n    = 1'b1;
    logic       mode = 1'b0, ss = 1'b0, clr = 1'b0, ld = 1'b0, lap = 1'b0, rd = 1'b0;
    logic [7:0] lmin = 8'h00, lsec = 8'h00;
    logic [7:0] min_o, sec_o, ms_10_o, lap_min_o, lap_sec_o, lap_ms_10_o;
    logic       running_o, time_out_o, lap_valid_o, lap_ovf_o;
    logic [2:0] lap_count_o;

    always #5 clk_core = ~clk_core;

    chrono_engine #(.TICK_DIV(TICK_DIV), .LAP_DEPTH(LAP_DEPTH), .MAX_MIN(MAX_MIN)) dut (
        .clk_core     (clk_core),
        .rst_n        (rst_n),
        .mode_i       (mode),
        .start_stop_i (ss),
        .clear_i      (clr),
        .load_i       (ld),
        .load_min_i   (lmin),
        .load_sec_i   (lsec),
        .lap_i        (lap),
        .lap_rd_i     (rd),
        .min_o        (min_o),
        .sec_o        (sec_o),
        .ms_10_o      (ms_10_o),
        .running_o    (running_o),
        .time_out_o   (time_out_o),
        .lap_min_o    (lap_min_o),
        .lap_sec_o    (lap_sec_o),
        .lap_ms_10_o  (lap_ms_10_o),
        .lap_valid_o  (lap_valid_o),
        .lap_count_o  (lap_count_o),
        .lap_ovf_o    (lap_ovf_o)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: time in centiseconds, activity flags, tick phase, lap queue.
    int m_cs, m_phase;
    bit m_run, m_pause, m_done, m_down, m_ovf;
    int m_q[$];

    function automatic logic [7:0] bcd2(input int x);
        return 8'(((x / 10) * 16) + (x % 10));
    endfunction

    function automatic logic [23:0] time_bcd(input int cs);
        return {bcd2(cs / 6000), bcd2((cs / 100) % 60), bcd2(cs % 100)};
    endfunction

    function automatic int clamp_field(input logic [7:0] raw, input int lim);
        int hi, lo;
        hi = int'(raw[7:4]);
        lo = int'(raw[3:0]);
        if (hi > 9 || lo > 9 || hi * 10 + lo > lim) return lim;
        return hi * 10 + lo;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cs = 0; m_phase = 0;
        m_run = 0; m_pause = 0; m_done = 0; m_down = 0; m_ovf = 0;
        m_q.delete();
    endtask

    task automatic model_edge();
        bit act, pop_ok, push_ok;
        if (clr) begin
            m_cs = 0; m_phase = 0; m_run = 0; m_pause = 0; m_done = 0; m_ovf = 0;
            m_q.delete();
        end else begin
            act     = m_run || m_pause;
            pop_ok  = rd && (m_q.size() > 0);
            push_ok = lap && act && (m_q.size() < LAP_DEPTH || pop_ok);
            if (lap && act && !push_ok) m_ovf = 1;
            if (pop_ok) void'(m_q.pop_front());
            if (push_ok) m_q.push_back(m_cs);
            if (m_done) begin
            end else if (m_run) begin
                if (ss) begin
                    m_run = 0; m_pause = 1;
                end else if (m_down && m_cs == 0) begin
                    m_run = 0; m_done = 1;
                end else begin
                    m_phase++;
                    if (m_phase == TICK_DIV) begin
                        m_phase = 0;
                        if (!m_down) begin
                            if (m_cs == MAX_CS) begin m_run = 0; m_done = 1; end
                            else m_cs++;
                        end else begin
                            m_cs--;
                            if (m_cs == 0) begin m_run = 0; m_done = 1; end
                        end
                    end
                end
            end else if (m_pause) begin
                if (ss) begin m_pause = 0; m_run = 1; m_phase = 0; end
            end else begin
                if (ld) m_cs = clamp_field(lmin, MAX_MIN) * 6000 + clamp_field(lsec, 59) * 100;
                else if (ss) begin m_run = 1; m_down = mode; m_phase = 0; end
            end
        end
    endtask

    task automatic compare_all();
        chk("time", {8'h00, min_o, sec_o, ms_10_o}, {8'h00, time_bcd(m_cs)});
        chk("flags", {28'h0, running_o, time_out_o, lap_valid_o, lap_ovf_o},
            {28'h0, m_run, m_done, m_q.size() > 0, m_ovf});
        chk("lap_count", 32'(lap_count_o), 32'(m_q.size()));
        chk("lap_head", {8'h00, lap_min_o, lap_sec_o, lap_ms_10_o},
            {8'h00, (m_q.size() > 0) ? time_bcd(m_q[0]) : 24'h0});
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk_core);
        #1;
        ss = 0; clr = 0; ld = 0; lap = 0; rd = 0;
        compare_all();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic ticks(input int n);
        run(n * TICK_DIV);
    endtask

    function automatic logic [31:0] shown();
        return {8'h00, min_o, sec_o, ms_10_o};
    endfunction

    int first_cs, tail_cs;

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        $display("reset asserted");
        compare_all();
        #6 rst_n = 1'b1;

        $display("step 1: count-up for 6100 ticks then pause");
        mode = 1'b0; ss = 1'b1; cycle();
        ticks(6100);
        chk("t1_time", shown(), 32'h0001_0100);
        chk("t1_running", 32'(running_o), 32'd1);
        ss = 1'b1; cycle();
        run(10);
        chk("t1_frozen", shown(), 32'h0001_0100);
        chk("t1_paused", 32'(running_o), 32'd0);

        $display("step 5b: start_stop coincident with a tick");
        ss = 1'b1; cycle();
        run(TICK_DIV - 1);
        ss = 1'b1; cycle();
        chk("t5_tick_dropped", shown(), 32'h0001_0100);
        ss = 1'b1; cycle();
        ticks(1);
        chk("t5_resumed", shown(), 32'h0001_0101);

        $display("step 2: countdown from 00:02");
        clr = 1'b1; cycle();
        ld = 1'b1; lmin = 8'h00; lsec = 8'h02; cycle();
        chk("t2_load", shown(), 32'h0000_0200);
        mode = 1'b1; ss = 1'b1; cycle();
        ticks(199);
        chk("t2_last", shown(), 32'h0000_0001);
        chk("t2_not_done", 32'(time_out_o), 32'd0);
        ticks(1);
        chk("t2_zero", shown(), 32'h0000_0000);
        chk("t2_done", 32'(time_out_o), 32'd1);
        ss = 1'b1; cycle();
        chk("t2_ss_ignored", {30'h0, time_out_o, running_o}, 32'h2);
        clr = 1'b1; cycle();
        chk("t2_cleared", {7'h0, running_o, time_out_o, min_o, sec_o, ms_10_o}, 32'h0);

        $display("step 2b: countdown started at zero");
        mode = 1'b1; ss = 1'b1; cycle();
        cycle();
        chk("t2b_done", 32'(time_out_o), 32'd1);
        clr = 1'b1; cycle();

        $display("step 3: saturation at 99:59.99");
        ld = 1'b1; lmin = 8'h99; lsec = 8'h59; cycle();
        mode = 1'b0; ss = 1'b1; cycle();
        ticks(99);
        chk("t3_top", shown(), 32'h0099_5999);
        chk("t3_not_done", 32'(time_out_o), 32'd0);
        ticks(2);
        chk("t3_hold", shown(), 32'h0099_5999);
        chk("t3_done", 32'(time_out_o), 32'd1);
        clr = 1'b1; cycle();

        $display("step 6: clamp and async reset mid-run");
        ld = 1'b1; lmin = 8'hA7; lsec = 8'h75; cycle();
        chk("t6_clamp", shown(), 32'h0099_5900);
        ss = 1'b1; cycle();
        ticks(3);
        lap = 1'b1; cycle();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6_async_time", shown(), 32'h0);
        chk("t6_async_flags", {29'h0, running_o, lap_valid_o, 1'b0} | 32'(lap_count_o), 32'h0);
        compare_all();
        #3 rst_n = 1'b1;
        cycle();

        $display("step 4: lap FIFO overflow and drain");
        mode = 1'b0; ss = 1'b1; cycle();
        for (int i = 0; i < 5; i++) begin
            run($urandom_range(TICK_DIV, 40));
            if (i == 0) first_cs = m_cs;
            lap = 1'b1; cycle();
        end
        chk("t4_count", 32'(lap_count_o), 32'd4);
        chk("t4_ovf", 32'(lap_ovf_o), 32'd1);
        chk("t4_head_first", {8'h00, lap_min_o, lap_sec_o, lap_ms_10_o}, {8'h00, time_bcd(first_cs)});

        $display("step 5a: push and pop together while full");
        run($urandom_range(TICK_DIV, 40));
        tail_cs = m_cs;
        lap = 1'b1; rd = 1'b1; cycle();
        chk("t5_count_full", 32'(lap_count_o), 32'd4);
        for (int i = 0; i < 3; i++) begin
            rd = 1'b1; cycle();
        end
        chk("t5_tail", {8'h00, lap_min_o, lap_sec_o, lap_ms_10_o}, {8'h00, time_bcd(tail_cs)});
        rd = 1'b1; cycle();
        chk("t4_drained", 32'(lap_valid_o), 32'd0);
        rd = 1'b1; cycle();
        chk("t4_pop_empty", 32'(lap_count_o), 32'd0);
        lap = 1'b1; rd = 1'b1; cycle();
        chk("t5_push_pop_empty", 32'(lap_count_o), 32'd1);
        clr = 1'b1; cycle();

        for (int it = 0; it < 8; it++) begin
            clr = 1'b1; cycle();
            ld = 1'b1;
            if (it % 4 == 1) begin
                lmin = 8'h00;
                lsec = bcd2($urandom_range(0, 2));
            end else if (it % 4 == 3) begin
                lmin = 8'($urandom);
                lsec = 8'($urandom);
            end else begin
                lmin = bcd2($urandom_range(0, 99));
                lsec = bcd2($urandom_range(0, 59));
            end
            mode = 1'($urandom_range(0, 1));
            $display("random run %0d: load %h:%h mode %0d", it, lmin, lsec, mode);
            cycle();
            ss = 1'b1; cycle();
            for (int c = 0; c < 400; c++) begin
                lap = ($urandom_range(0, 5) == 0);
                rd  = ($urandom_range(0, 5) == 0);
                ss  = ($urandom_range(0, 60) == 0);
                cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/chrono_engine.md
Name: chrono_engine

Overview:
Parametrised timekeeping core for the counter board: one engine handles both stopwatch (count-up) and countdown (count-down) modes with a BCD min/sec/10 ms time base. It adds an internal 10 ms prescaler, preset loading and a lap-record FIFO of configurable depth. It sits between the debounced button pulses and the seven-segment display mux, replacing the separate up-counter and down-counter commanders.

Parameters:
TICK_DIV, 100000, clk_core cycles per 10 ms tick (>=2)
LAP_DEPTH, 4, lap FIFO entries (power of 2, 2..16)
MAX_MIN, 99, maximum minute value (BCD-representable, <=99)

Ports:
clk_core  in  1  core clock
rst_n  in  1  async active-low reset
mode_i  in  1  0 = count-up, 1 = count-down; sampled only in IDLE
start_stop_i  in  1  single-cycle pulse: start/pause/resume
clear_i  in  1  single-cycle pulse: return to IDLE, zero time, flush FIFO
load_i  in  1  single-cycle pulse: load preset (IDLE only)
load_min_i  in  8  preset minutes, BCD
load_sec_i  in  8  preset seconds, BCD
lap_i  in  1  single-cycle pulse: record current time
lap_rd_i  in  1  single-cycle pulse: pop oldest lap
min_o  out  8  current minutes, BCD
sec_o  out  8  current seconds, BCD
ms_10_o  out  8  current 10 ms units, BCD
running_o  out  1  high in RUN
time_out_o  out  1  high in DONE
lap_min_o / lap_sec_o / lap_ms_10_o  out  8 each  head-of-FIFO entry (valid when lap_valid_o)
lap_valid_o  out  1  FIFO not empty
lap_count_o  out  $clog2(LAP_DEPTH)+1  entries held
lap_ovf_o  out  1  sticky: a lap was dropped while full

Behaviour:
- Reset (async, rst_n=0): state IDLE, all time, lap outputs and counters 0, flags 0, mode register 0.
- States: IDLE, RUN, PAUSE, DONE.
  IDLE -start_stop-> RUN (mode_i latched at that edge); PAUSE -start_stop-> RUN; RUN -start_stop-> PAUSE; RUN -terminal reached-> DONE; any state -clear-> IDLE.
- Prescaler: counts 0..TICK_DIV-1 only in RUN; reset to 0 on every IDLE/PAUSE->RUN transition and on clear; tick is asserted on the cycle the prescaler reaches TICK_DIV-1. Time updates one cycle after the tick (registered).
- Count-up: ms_10 00..99 -> sec 00..59 -> min 00..MAX_MIN, BCD digit-wise carry. At MAX_MIN:59.99 the next tick holds the value and enters DONE.
- Count-down: BCD borrow in reverse order. A tick at 00:00.01 yields 00:00.00 and enters DONE on the same update. Start from 00:00.00 in down mode goes straight to DONE on the next cycle.
- load_i (IDLE only): min = load_min_i, sec = load_sec_i, ms_10 = 00. Values that are not valid BCD, sec>59 or min>MAX_MIN are clamped to MAX_MIN / 59. load_i outside IDLE is ignored.
- DONE: time frozen, time_out_o=1, start_stop ignored; only clear exits.
- Lap FIFO: lap_i in RUN or PAUSE pushes {min,sec,ms_10} as displayed that cycle. Ignored in IDLE/DONE.
  - Full and no pop: entry dropped, lap_ovf_o set (sticky until clear).
  - Simultaneous push+pop when full: both occur and count is unchanged.
  - Simultaneous push+pop when empty: push only.
  - Pop when empty: ignored.
  - Head outputs are registered, with 0 latency from the FIFO state; they are zero when empty.
- Priority within a cycle: clear > load > start_stop > tick. A tick coincident with start_stop (RUN->PAUSE) is discarded. A lap coincident with a tick captures the pre-tick value.
- Reset mid-RUN: immediate return to reset values; no partial FIFO write.

Decomposition:
- chrono_pkg holds the state enum, the BCD limit constants (8'h59, 8'h99) and the lap entry struct width (24).
- One sub-module is natural: bcd_time_step, a combinational increment/decrement of {min,sec,ms_10} with carry/borrow and a terminal flag, parametrised by MAX_MIN.
- The FIFO is inline.

Test Plan (TICK_DIV=4, LAP_DEPTH=4):
1. Up count: start, run 6100 ticks -> min_o=01, sec_o=01, ms_10_o=00, running_o=1; start_stop -> values frozen, running_o=0.
2. Down count: load 00:02, mode_i=1, start, after 200 ticks -> 00:00.00, time_out_o=1, start_stop ignored; clear -> IDLE, all 0.
3. Wrap/saturation: load 99:59 in up mode and advance to 99:59.99; one more tick -> hold at 99:59.99, time_out_o=1.
4. Lap FIFO: 5 laps at distinct times with no reads -> lap_count_o=4, lap_ovf_o=1, head = first lap; 4 pops -> lap_valid_o=0.
5. Collisions: push+pop same cycle when full -> count stays 4, new tail correct; start_stop coincident with tick -> the tick is not applied.
6. Clamp and async reset: load 8'hA7/8'h75 -> 99:59.00; assert rst_n mid-RUN between clock edges -> outputs 0 immediately.
